rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- Parametrised successor to the combinational 4-way data mux.
- N-channel registered multiplexer with valid/ready handshakes per input and round-robin arbitration.
- One-entry output register.
- Used where several datapath sources share one sink, e.g. instruction fetch, data load/store and debug ports sharing the memory request bus.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  sink accept.
- out_sel  output  SEL_W  registered index of the channel held in the output register.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - last_grant=CHANNELS-1, so channel 0 wins first.
- load_en = !out_valid | out_ready.
- Arbitration (combinational):
  - Search in_valid starting at (last_grant+1) mod CHANNELS, wrapping.
  - First set bit is grant; any_req = |in_valid.
  - Wrap-around: with last_grant=CHANNELS-1 the search starts at 0.
- Handshakes:
  - in_ready[i] = load_en & any_req & (grant==i).
  - At most one in_ready bit is high in any cycle.
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - Sources must hold in_data/in_valid stable until accepted.
- Clock edge with load_en & any_req:
  - out_data <= channel[grant], out_sel <= grant, out_valid <= 1, last_grant <= grant.
- Clock edge with load_en & !any_req: out_valid <= 0; out_data and out_sel hold.
- Clock edge with !load_en (out_valid=1, out_ready=0):
  - All registers hold; no in_ready asserted (backpressure).
- Latency and throughput:
  - Latency: 1 cycle from accepted input to out_valid.
  - Throughput: 1 word/cycle with out_ready held high.
- Simultaneous drain and refill: out_ready=1 with out_valid=1 and a request pending drains the old word and loads the new one on the same edge; no bubble.
- Fairness: a channel with in_valid continuously high is served within CHANNELS grants.
- Reset mid-transfer: the held word is discarded, out_valid drops immediately (asynchronous), and arbitration restarts at channel 0.
- No combinational path from out_ready to out_data/out_valid; the only combinational path is out_ready -> in_ready.

Optional Feature:
- Macro RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input in_lock, width CHANNELS.
  - A transfer from channel g with in_lock[g]=1 sets a lock flag.
  - While locked, grant is forced to g regardless of other requests; channel g may also idle, with in_valid[g]=0 producing no grant.
  - The lock clears on the first transfer from g with in_lock[g]=0 (last beat of a burst).
  - last_grant still updates to g.
  - The lock flag resets to 0.
- Undefined: port absent; pure round-robin per beat.

Decomposition:
- Package rr_arb_mux_pkg:
  - function rr_pick(req, last) returning the grant index and any_req.
  - localparam CHANNELS_MAX=16.
- Sub-module rr_arbiter (priority rotation and grant, combinational):
  - Kept separate so it can be reused by the register-file write-port arbiter.
  - rr_arb_mux instantiates it and owns the output register and the lock flag.

Test Plan:
- Single request: reset; in_valid=4'b0100, ch2=32'hdeadbeef, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=deadbeef, out_sel=2; then out_valid=0.
- Rotation: in_valid=4'b1111 held, out_ready=1, channel data 0xA0..0xA3 -> grants 0,1,2,3,0 on consecutive cycles; out_data A0,A1,A2,A3,A0 one cycle later.
- Backpressure: out_valid=1 holding 0x11 with out_ready=0 for 3 cycles, in_valid=4'b0011 -> in_ready=0 and out_data=0x11 stable; on out_ready=1 the same edge loads the next grant, with no bubble.
- Wrap and skip: last_grant=2, in_valid=4'b0010 -> grant 1, wrapping past channel 3.
- Reset mid-operation: out_valid=1 with out_ready=0, rst_n pulsed low asynchronously -> out_valid falls before the next edge; after release with in_valid=4'b1001, grant is 0.
- Lock (RR_ARB_MUX_LOCK_EN): ch1 sends 3 beats with in_lock[1]=1,1,0 while in_valid=4'b1111 -> out_sel=1,1,1, then 2.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin arbitrated mux and its arbiter.
package rr_arb_mux_pkg;

  localparam int CHANNELS_MAX = 16;

  // Searches req starting one past last and wrapping at n. Returns any_req.
  // idx holds the first requester found, or 0 when nothing requests.
  function automatic logic rr_pick(input logic [CHANNELS_MAX-1:0] req,
                                   input int last, input int n,
                                   output int idx);
    logic found;
    int   cand;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= CHANNELS_MAX; k++) begin
      cand = (last + k) % n;
      if (k <= n && !found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Combinational round-robin grant: priority rotates to the channel after last.
module rr_arbiter
  import rr_arb_mux_pkg::*;
#(
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic [SEL_W-1:0]    grant,
  output logic                any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    any_req = rr_pick(CHANNELS_MAX'(req), int'(last), CHANNELS, idx);
    grant   = SEL_W'(idx);
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrated mux with a one-entry output register.
// Define RR_ARB_MUX_LOCK_EN to add in_lock for multi-beat burst locking.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_lock,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             vld_p1;
  logic [SEL_W-1:0] last_grant;

  logic [SEL_W-1:0] rr_grant;
  logic             rr_any;
  logic [SEL_W-1:0] grant;
  logic             any_req;
  logic             load_en;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req     (in_valid),
    .last    (last_grant),
    .grant   (rr_grant),
    .any_req (rr_any)
  );

  assign load_en = !vld_p1 | out_ready;

`ifdef RR_ARB_MUX_LOCK_EN
  logic             lock_p1;
  logic [SEL_W-1:0] lock_ch_p1;

  // A locked burst owns the output; an idle locked source yields no grant.
  always_comb begin
    grant   = rr_grant;
    any_req = rr_any;
    if (lock_p1) begin
      grant   = lock_ch_p1;
      any_req = in_valid[lock_ch_p1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_p1    <= 1'b0;
      lock_ch_p1 <= '0;
    end else if (load_en && any_req) begin
      lock_p1    <= in_lock[grant];
      lock_ch_p1 <= grant;
    end
  end
`else
  assign grant   = rr_grant;
  assign any_req = rr_any;
`endif

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++)
      in_ready[i] = load_en & any_req & (grant == SEL_W'(i));
  end

  // Stage p1: output register, loaded whenever it is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1    <= '0;
      sel_p1     <= '0;
      vld_p1     <= 1'b0;
      last_grant <= SEL_W'(CHANNELS - 1);
    end else if (load_en) begin
      if (any_req) begin
        data_p1    <= in_data[int'(grant)*WIDTH +: WIDTH];
        sel_p1     <= grant;
        vld_p1     <= 1'b1;
        last_grant <= grant;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;

endmodule
